// File: rtl/chameleon_spi_pkg.sv
// chameleon_spi_pkg: shared state encoding and constants for the SPI arbiter
package chameleon_spi_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT, DONE, HOLD, GAP} state_t;
    localparam logic HOST = 1'b0;
    localparam logic AUX = 1'b1;
    localparam int CS_W = 2;
    localparam int HALF_W = 16;
endpackage

// File: rtl/chameleon_spi_byte_engine.sv
// chameleon_spi_byte_engine: SPI mode-0 byte shifter with half-period divider
module chameleon_spi_byte_engine
    import chameleon_spi_pkg::*;
(
    input  logic              sysclk,
    input  logic              n_reset,
    input  logic              start,
    input  logic [HALF_W-1:0] half,
    input  logic [7:0]        wdata,
    input  logic              miso,
    output logic              done,
    output logic [7:0]        rdata,
    output logic              spi_clk,
    output logic              spi_mosi
);
    logic              active;
    logic [HALF_W-1:0] hreg;
    logic [HALF_W-1:0] cnt;
    logic [2:0]        bits;
    logic [7:0]        tx;
    logic              phase_end;

    assign phase_end = active && (cnt == hreg);
    assign done = phase_end && spi_clk && (bits == 3'd7);

    // Rising spi_clk samples MISO, falling spi_clk advances MOSI; MOSI idles high
    always_ff @(posedge sysclk or negedge n_reset) begin
        if (!n_reset) begin
            active <= 1'b0;
            hreg <= '0;
            cnt <= '0;
            bits <= '0;
            tx <= '0;
            rdata <= '0;
            spi_clk <= 1'b0;
            spi_mosi <= 1'b1;
        end else if (start) begin
            active <= 1'b1;
            hreg <= half;
            cnt <= HALF_W'(1);
            bits <= '0;
            tx <= wdata;
            spi_clk <= 1'b0;
            spi_mosi <= wdata[7];
        end else if (phase_end) begin
            cnt <= HALF_W'(1);
            spi_clk <= ~spi_clk;
            if (!spi_clk) begin
                rdata <= {rdata[6:0], miso};
            end else begin
                bits <= bits + 3'd1;
                tx <= {tx[6:0], 1'b1};
                spi_mosi <= done | tx[6];
                active <= ~done;
            end
        end else if (active) begin
            cnt <= cnt + HALF_W'(1);
        end
    end
endmodule

// File: rtl/chameleon_spi_arbiter.sv
// chameleon_spi_arbiter: round-robin sharing of one SPI bus between host and aux byte requesters
module chameleon_spi_arbiter
    import chameleon_spi_pkg::*;
#(
    parameter int CLKDIV = 2,
    parameter int SLOWDIV = 64
) (
    input  logic            sysclk,
    input  logic            n_reset,
    input  logic            h_req,
    input  logic            a_req,
    input  logic            h_lock,
    input  logic            a_lock,
    input  logic [CS_W-1:0] h_cs,
    input  logic [CS_W-1:0] a_cs,
    input  logic            h_fast,
    input  logic            a_fast,
    input  logic [7:0]      h_wdata,
    input  logic [7:0]      a_wdata,
    output logic            h_ack,
    output logic            a_ack,
    output logic [7:0]      h_rdata,
    output logic [7:0]      a_rdata,
    output logic [1:0]      grant,
    output logic            busy,
    output logic            spi_clk,
    output logic            spi_mosi,
    input  logic            spi_miso,
    output logic [CS_W-1:0] spi_cs_n
);
    state_t            state;
    state_t            next;
    logic              last;
    logic              own;
    logic              sel;
    logic              start;
    logic              sel_req;
    logic              sel_lock;
    logic              sel_fast;
    logic [CS_W-1:0]   sel_cs;
    logic [7:0]        sel_wdata;
    logic [HALF_W-1:0] sel_half;
    logic [HALF_W-1:0] gap_half;
    logic [HALF_W-1:0] gcnt;
    logic              fast_lat;
    logic              eng_done;
    logic [7:0]        eng_rdata;

    assign own = grant[AUX];
    assign sel = (state == IDLE) ? (a_req && (!h_req || last == HOST)) : own;
    assign sel_req = sel ? a_req : h_req;
    assign sel_lock = sel ? a_lock : h_lock;
    assign sel_fast = sel ? a_fast : h_fast;
    assign sel_cs = sel ? a_cs : h_cs;
    assign sel_wdata = sel ? a_wdata : h_wdata;
    assign sel_half = sel_fast ? HALF_W'(CLKDIV) : HALF_W'(SLOWDIV);
    assign gap_half = fast_lat ? HALF_W'(CLKDIV) : HALF_W'(SLOWDIV);
    assign busy = (state != IDLE);

    // Arbiter state register
    always_ff @(posedge sysclk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else state <= next;
    end

    // Next state and byte start; req is only looked at in IDLE and HOLD
    always_comb begin
        next = state;
        start = 1'b0;
        case (state)
            IDLE: if (h_req || a_req) begin
                next = SHIFT;
                start = 1'b1;
            end
            SHIFT: if (eng_done) next = DONE;
            DONE: next = sel_lock ? HOLD : GAP;
            HOLD: if (sel_req) begin
                next = SHIFT;
                start = 1'b1;
            end else if (!sel_lock) begin
                next = GAP;
            end
            GAP: if (gcnt == gap_half) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Grant, chip selects, release gap, round-robin pointer and per-port results
    always_ff @(posedge sysclk or negedge n_reset) begin
        if (!n_reset) begin
            grant <= '0;
            last <= AUX;
            fast_lat <= 1'b1;
            gcnt <= '0;
            spi_cs_n <= '1;
            h_ack <= 1'b0;
            a_ack <= 1'b0;
            h_rdata <= '0;
            a_rdata <= '0;
        end else begin
            h_ack <= eng_done && !own;
            a_ack <= eng_done && own;
            if (eng_done && !own) h_rdata <= eng_rdata;
            if (eng_done && own) a_rdata <= eng_rdata;
            if (start) fast_lat <= sel_fast;
            if (state == IDLE && start) begin
                grant <= {sel, !sel};
                spi_cs_n <= ~sel_cs;
            end
            if (state != GAP && next == GAP) begin
                spi_cs_n <= '1;
                gcnt <= HALF_W'(1);
            end
            if (state == GAP) begin
                gcnt <= gcnt + HALF_W'(1);
                if (next == IDLE) begin
                    grant <= '0;
                    last <= own;
                end
            end
        end
    end

    chameleon_spi_byte_engine u_engine (
        .sysclk   (sysclk),
        .n_reset  (n_reset),
        .start    (start),
        .half     (sel_half),
        .wdata    (sel_wdata),
        .miso     (spi_miso),
        .done     (eng_done),
        .rdata    (eng_rdata),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi)
    );
endmodule

// File: tb/tb_chameleon_spi_arbiter.sv
// tb_chameleon_spi_arbiter: directed and randomized checks against an SPI slave model
module tb_chameleon_spi_arbiter;
    localparam int CLKDIV = 2;
    localparam int SLOWDIV = 64;

    logic       sysclk = 1'b0;
    logic       n_reset = 1'b1;
    logic       h_req = 1'b0, a_req = 1'b0, h_lock = 1'b0, a_lock = 1'b0;
    logic       h_fast = 1'b1, a_fast = 1'b1;
    logic [1:0] h_cs = 2'b00, a_cs = 2'b00;
    logic [7:0] h_wdata = 8'h00, a_wdata = 8'h00;
    logic       h_ack, a_ack, busy, spi_clk, spi_mosi, spi_miso;
    logic [7:0] h_rdata, a_rdata;
    logic [1:0] grant, spi_cs_n;

    int checks = 0;
    int errors = 0;

    logic       loop = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    int         base = 0;
    int         rise_cnt = 0;
    logic [7:0] mosi_sh = 8'h00;

    logic [1:0] cs_or, cs_and, grant_or;
    logic       mosi_and;
    int         h_acks = 0, a_acks = 0;
    int         hi_run = 0, hi_min = 0, hi_max = 0;

    chameleon_spi_arbiter #(.CLKDIV(CLKDIV), .SLOWDIV(SLOWDIV)) dut (
        .sysclk(sysclk), .n_reset(n_reset),
        .h_req(h_req), .a_req(a_req), .h_lock(h_lock), .a_lock(a_lock),
        .h_cs(h_cs), .a_cs(a_cs), .h_fast(h_fast), .a_fast(a_fast),
        .h_wdata(h_wdata), .a_wdata(a_wdata),
        .h_ack(h_ack), .a_ack(a_ack), .h_rdata(h_rdata), .a_rdata(a_rdata),
        .grant(grant), .busy(busy),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
    );

    always #5 sysclk = ~sysclk;

    // Mode-0 slave: shifts out slave_byte MSB first, records MOSI on each rising edge
    assign spi_miso = loop ? spi_mosi : slave_byte[3'(7 - (rise_cnt - base))];

    always @(posedge spi_clk) begin
        rise_cnt <= rise_cnt + 1;
        mosi_sh <= {mosi_sh[6:0], spi_mosi};
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
        cs_or = cs_or | spi_cs_n;
        cs_and = cs_and & spi_cs_n;
        mosi_and = mosi_and & spi_mosi;
        grant_or = grant_or | grant;
        h_acks += int'(h_ack);
        a_acks += int'(a_ack);
        if (spi_clk) hi_run++;
        else if (hi_run > 0) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            hi_run = 0;
        end
    endtask

    task automatic clear_flags();
        cs_or = 2'b00;
        cs_and = 2'b11;
        mosi_and = 1'b1;
        grant_or = 2'b00;
        hi_run = 0;
        hi_min = 1000000;
        hi_max = 0;
    endtask

    task automatic wait_ack(input bit aux, input int limit, output int lat);
        lat = 0;
        while (!(aux ? a_ack : h_ack) && lat < limit) begin
            tick();
            lat++;
        end
        if (!(aux ? a_ack : h_ack)) lat = -1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && busy; i++) tick();
        tick();
    endtask

    task automatic do_reset();
        h_req = 1'b0; a_req = 1'b0; h_lock = 1'b0; a_lock = 1'b0;
        #2 n_reset = 1'b0;
        repeat (2) tick();
        n_reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2 n_reset = 1'b0;
        #3;
        checks++;
        if ({spi_clk, spi_mosi, spi_cs_n} !== 4'b0111) begin
            errors++;
            $display("FAIL reset_spi got clk/mosi/cs_n=%b want 0111", {spi_clk, spi_mosi, spi_cs_n});
        end
        checks++;
        if ({h_ack, a_ack, grant, busy} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl got ack/grant/busy=%b want 00000", {h_ack, a_ack, grant, busy});
        end
        checks++;
        if ({h_rdata, a_rdata} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0000", {h_rdata, a_rdata});
        end
        repeat (2) tick();
        n_reset = 1'b1;
        tick();
    endtask

    task automatic test_host_byte();
        int lat, r0, a0;
        loop = 1'b1;
        clear_flags();
        a0 = a_acks;
        r0 = rise_cnt;
        h_cs = 2'b01; h_wdata = 8'hA5; h_fast = 1'b1; h_req = 1'b1;
        tick();
        checks++;
        if ({spi_cs_n, spi_mosi, grant} !== 5'b10101) begin
            errors++;
            $display("FAIL host_cycle1 got cs_n/mosi/grant=%b want 10101", {spi_cs_n, spi_mosi, grant});
        end
        wait_ack(1'b0, 200, lat);
        h_req = 1'b0;
        checks++;
        if (lat + 1 !== 16 * CLKDIV + 1) begin
            errors++;
            $display("FAIL host_latency got %0d want %0d", lat + 1, 16 * CLKDIV + 1);
        end
        checks++;
        if (h_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL host_rdata got %h want a5", h_rdata);
        end
        checks++;
        if (rise_cnt - r0 !== 8) begin
            errors++;
            $display("FAIL host_rises got %0d want 8", rise_cnt - r0);
        end
        checks++;
        if (cs_or[0] !== 1'b0) begin
            errors++;
            $display("FAIL host_cs_held got cs_or=%b want bit0 0", cs_or);
        end
        tick();
        checks++;
        if (h_ack !== 1'b0 || a_acks !== a0) begin
            errors++;
            $display("FAIL host_ack_pulse got h_ack=%b a_acks=%0d want 0 %0d", h_ack, a_acks, a0);
        end
        wait_idle();
    endtask

    task automatic test_round_robin();
        int lat, n, hi;
        do_reset();
        loop = 1'b1;
        h_cs = 2'b01; h_wdata = 8'h3C; h_fast = 1'b1;
        a_cs = 2'b10; a_wdata = 8'hC3; a_fast = 1'b1;
        h_req = 1'b1; a_req = 1'b1;
        wait_ack(1'b0, 200, lat);
        h_req = 1'b0;
        checks++;
        if (lat !== 16 * CLKDIV + 1 || grant !== 2'b01 || h_rdata !== 8'h3C) begin
            errors++;
            $display("FAIL rr_host_first got lat=%0d grant=%b rdata=%h want %0d 01 3c", lat, grant, h_rdata, 16 * CLKDIV + 1);
        end
        n = 0;
        hi = 0;
        while (spi_cs_n[1] && n < 200) begin
            tick();
            n++;
            if (spi_cs_n == 2'b11) hi++;
        end
        checks++;
        if (hi < CLKDIV || spi_cs_n !== 2'b01 || grant !== 2'b10) begin
            errors++;
            $display("FAIL rr_gap got gap=%0d cs_n=%b grant=%b want >=%0d 01 10", hi, spi_cs_n, grant, CLKDIV);
        end
        wait_ack(1'b1, 200, lat);
        a_req = 1'b0;
        checks++;
        if (lat < 0 || n + lat !== 17 * CLKDIV + 2) begin
            errors++;
            $display("FAIL rr_aux_latency got %0d want %0d", n + lat, 17 * CLKDIV + 2);
        end
        checks++;
        if (a_rdata !== 8'hC3 || h_rdata !== 8'h3C) begin
            errors++;
            $display("FAIL rr_rdata got a=%h h=%h want c3 3c", a_rdata, h_rdata);
        end
        wait_idle();
    endtask

    task automatic test_lock();
        int lat, a0;
        logic [7:0] data [3];
        data[0] = 8'h11; data[1] = 8'h69; data[2] = 8'hF0;
        loop = 1'b1;
        clear_flags();
        a0 = a_acks;
        h_cs = 2'b01; h_fast = 1'b1; h_lock = 1'b1;
        h_wdata = data[0]; h_req = 1'b1;
        wait_ack(1'b0, 200, lat);
        h_req = 1'b0;
        a_cs = 2'b10; a_wdata = 8'h5A; a_fast = 1'b1; a_req = 1'b1;
        for (int b = 1; b < 3; b++) begin
            checks++;
            if (h_rdata !== data[b-1]) begin
                errors++;
                $display("FAIL lock_rdata%0d got %h want %h", b - 1, h_rdata, data[b-1]);
            end
            h_wdata = data[b];
            h_req = 1'b1;
            tick();
            wait_ack(1'b0, 200, lat);
            h_req = 1'b0;
            checks++;
            if (lat !== 16 * CLKDIV + 1) begin
                errors++;
                $display("FAIL lock_latency%0d got %0d want %0d", b, lat, 16 * CLKDIV + 1);
            end
        end
        h_lock = 1'b0;
        checks++;
        if (h_rdata !== data[2]) begin
            errors++;
            $display("FAIL lock_rdata2 got %h want %h", h_rdata, data[2]);
        end
        checks++;
        if (cs_or[0] !== 1'b0 || grant_or !== 2'b01 || a_acks !== a0) begin
            errors++;
            $display("FAIL lock_held got cs_or=%b grant_or=%b a_acks=%0d want 0x 01 %0d", cs_or, grant_or, a_acks, a0);
        end
        wait_ack(1'b1, 200, lat);
        a_req = 1'b0;
        checks++;
        if (lat !== 17 * CLKDIV + 2 || a_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL lock_aux got lat=%0d rdata=%h want %0d 5a", lat, a_rdata, 17 * CLKDIV + 2);
        end
        wait_idle();
    endtask

    task automatic test_slow();
        int lat, r0;
        loop = 1'b1;
        clear_flags();
        r0 = rise_cnt;
        h_cs = 2'b01; h_wdata = 8'h4B; h_fast = 1'b0; h_req = 1'b1;
        wait_ack(1'b0, 1200, lat);
        h_req = 1'b0;
        h_fast = 1'b1;
        checks++;
        if (lat !== 16 * SLOWDIV + 1 || h_rdata !== 8'h4B) begin
            errors++;
            $display("FAIL slow_byte got lat=%0d rdata=%h want %0d 4b", lat, h_rdata, 16 * SLOWDIV + 1);
        end
        checks++;
        if (hi_min !== SLOWDIV || hi_max !== SLOWDIV || rise_cnt - r0 !== 8) begin
            errors++;
            $display("FAIL slow_phase got hi=%0d..%0d rises=%0d want %0d 8", hi_min, hi_max, rise_cnt - r0, SLOWDIV);
        end
        wait_idle();
    endtask

    task automatic test_no_cs();
        int lat, r0;
        loop = 1'b1;
        clear_flags();
        r0 = rise_cnt;
        h_cs = 2'b00; h_wdata = 8'hFF; h_fast = 1'b1; h_req = 1'b1;
        wait_ack(1'b0, 200, lat);
        h_req = 1'b0;
        checks++;
        if (cs_and !== 2'b11 || mosi_and !== 1'b1) begin
            errors++;
            $display("FAIL nocs_lines got cs_and=%b mosi_and=%b want 11 1", cs_and, mosi_and);
        end
        checks++;
        if (lat !== 16 * CLKDIV + 1 || h_rdata !== 8'hFF || rise_cnt - r0 !== 8) begin
            errors++;
            $display("FAIL nocs_byte got lat=%0d rdata=%h rises=%0d want %0d ff 8", lat, h_rdata, rise_cnt - r0, 16 * CLKDIV + 1);
        end
        wait_idle();
    endtask

    task automatic test_async_reset();
        int lat, h0;
        loop = 1'b1;
        h_cs = 2'b01; h_wdata = 8'hE7; h_fast = 1'b1; h_req = 1'b1;
        tick();
        h_req = 1'b0;
        repeat (9) tick();
        h0 = h_acks;
        #2 n_reset = 1'b0;
        #1;
        checks++;
        if ({spi_clk, spi_mosi, spi_cs_n, busy, grant} !== 7'b0111000) begin
            errors++;
            $display("FAIL areset_now got clk/mosi/cs_n/busy/grant=%b want 0111000", {spi_clk, spi_mosi, spi_cs_n, busy, grant});
        end
        repeat (3) tick();
        n_reset = 1'b1;
        repeat (2) tick();
        checks++;
        if (h_acks !== h0 || busy !== 1'b0 || h_rdata !== 8'h00) begin
            errors++;
            $display("FAIL areset_noack got acks=%0d busy=%b rdata=%h want %0d 0 00", h_acks, busy, h_rdata, h0);
        end
        h_wdata = 8'h96; h_req = 1'b1;
        wait_ack(1'b0, 200, lat);
        h_req = 1'b0;
        checks++;
        if (lat !== 16 * CLKDIV + 1 || h_rdata !== 8'h96) begin
            errors++;
            $display("FAIL areset_after got lat=%0d rdata=%h want %0d 96", lat, h_rdata, 16 * CLKDIV + 1);
        end
        wait_idle();
    endtask

    task automatic test_random();
        int lat, mode, hf_first;
        bit both, first, last, hf, af, lh, la;
        logic [7:0] hw, aw, hs, as, w_exp, r_exp;
        do_reset();
        last = 1'b1;
        for (int it = 0; it < 16; it++) begin
            mode = int'($urandom_range(0, 2));
            both = (mode == 2);
            hw = 8'($urandom); aw = 8'($urandom); hs = 8'($urandom); as = 8'($urandom);
            hf = both || ($urandom_range(0, 7) != 0);
            af = both || ($urandom_range(0, 7) != 0);
            lh = 1'($urandom); la = 1'($urandom);
            first = both ? !last : (mode == 1);
            h_cs = 2'b01; h_wdata = hw; h_fast = hf;
            a_cs = 2'b10; a_wdata = aw; a_fast = af;
            loop = first ? la : lh;
            slave_byte = first ? as : hs;
            base = rise_cnt;
            h_req = (mode != 1); a_req = (mode != 0);
            wait_ack(first, 1200, lat);
            if (first) a_req = 1'b0; else h_req = 1'b0;
            hf_first = (first ? af : hf) ? CLKDIV : SLOWDIV;
            w_exp = first ? aw : hw;
            r_exp = loop ? w_exp : slave_byte;
            checks++;
            if (lat !== 16 * hf_first + 1 || (first ? a_rdata : h_rdata) !== r_exp || mosi_sh !== w_exp) begin
                errors++;
                $display("FAIL rand%0d_first port=%0d lat=%0d rdata=%h mosi=%h want %0d %h %h", it, first,
                         lat, first ? a_rdata : h_rdata, mosi_sh, 16 * hf_first + 1, r_exp, w_exp);
            end
            last = first;
            if (both) begin
                loop = first ? lh : la;
                slave_byte = first ? hs : as;
                base = rise_cnt;
                wait_ack(!first, 1200, lat);
                if (first) h_req = 1'b0; else a_req = 1'b0;
                w_exp = first ? hw : aw;
                r_exp = loop ? w_exp : slave_byte;
                checks++;
                if (lat !== hf_first + 16 * CLKDIV + 2 || (first ? h_rdata : a_rdata) !== r_exp || mosi_sh !== w_exp) begin
                    errors++;
                    $display("FAIL rand%0d_second port=%0d lat=%0d rdata=%h mosi=%h want %0d %h %h", it, !first,
                             lat, first ? h_rdata : a_rdata, mosi_sh, hf_first + 16 * CLKDIV + 2, r_exp, w_exp);
                end
                last = !first;
            end
            wait_idle();
        end
    endtask

    initial begin
        clear_flags();
        test_reset();
        test_host_byte();
        test_round_robin();
        test_lock();
        test_slow();
        test_no_cs();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
